// File: rtl/pkt_sf_fifo.sv
// pkt_sf_fifo: store-and-forward packet FIFO for the 156.25 MHz packet domain.
// Whole packets are buffered before they become readable. Bad packets,
// packets with broken sop/eop framing and packets that overflow the buffer
// are rewound out of storage and counted in drop_cnt.
module pkt_sf_fifo #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 256,
  parameter int FULL_THRESH = 4,
  parameter int DROP_ERR    = 1,
  parameter int CNT_W       = 16,
  localparam int MOD_W      = $clog2(DATA_W / 8)
) (
  input  logic              clk_156m25,
  input  logic              reset_156m25_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_val,
  input  logic              in_sop,
  input  logic              in_eop,
  input  logic [MOD_W-1:0]  in_mod,
  input  logic              in_err,
  output logic              in_full,
  input  logic              out_ren,
  output logic              out_avail,
  output logic [DATA_W-1:0] out_data,
  output logic              out_val,
  output logic              out_sop,
  output logic              out_eop,
  output logic [MOD_W-1:0]  out_mod,
  output logic              out_err,
  output logic [CNT_W-1:0]  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int EW = DATA_W + MOD_W + 3;

  localparam logic [PW-1:0] DEPTH_P  = PW'(DEPTH);
  localparam logic [PW-1:0] THRESH_P = PW'(FULL_THRESH);
  localparam logic [PW-1:0] ONE_P    = PW'(1);
  localparam bit            DROP_EN  = (DROP_ERR != 0);

  // Write FSM encoding
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PKT     = 2'd1;
  localparam logic [1:0] S_DISCARD = 2'd2;

  // Entry layout: {data, mod, sop, eop, err}
  logic [EW-1:0]     mem_q [DEPTH];

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     wr_commit_q, wr_commit_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     pkt_count_q, pkt_count_d;
  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic              in_full_q, in_full_d;
  logic              out_avail_q, out_avail_d;

  logic              out_val_q, out_sop_q, out_eop_q, out_err_q;
  logic [DATA_W-1:0] out_data_q;
  logic [MOD_W-1:0]  out_mod_q;

  logic              full_s;
  logic              committed_full_s;
  logic              we_s;
  logic [AW-1:0]     waddr_s;
  logic [EW-1:0]     wdata_s;
  logic [1:0]        drop_inc_s;
  logic              pkt_inc_s;
  logic              pkt_dec_s;
  logic              rd_en_s;
  logic [EW-1:0]     rd_entry_s;
  logic              take_start_s;
  logic              repair_s;
  logic [CNT_W:0]    drop_sum_s;
  logic [PW-1:0]     free_d_s;

  // Outcome of starting a packet with the current word at wr_commit
  logic              st_we_s;
  logic [PW-1:0]     st_ptr_s;
  logic [PW-1:0]     st_commit_s;
  logic [1:0]        st_state_s;
  logic              st_drop_s;
  logic              st_pkt_s;

  // Occupancy flags use pre-read pointers; a same-cycle read does not free space early
  always_comb begin
    full_s           = ((wr_ptr_q - rd_ptr_q) == DEPTH_P);
    committed_full_s = ((wr_commit_q - rd_ptr_q) == DEPTH_P);
    wdata_s          = {in_data, in_mod, in_sop, in_eop, in_err & in_eop};
    rd_entry_s       = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Evaluate what happens if the current word opens a new packet at wr_commit
  always_comb begin
    st_we_s     = 1'b0;
    st_ptr_s    = wr_commit_q;
    st_commit_s = wr_commit_q;
    st_state_s  = S_IDLE;
    st_drop_s   = 1'b0;
    st_pkt_s    = 1'b0;
    if (committed_full_s) begin
      // No room even for the first word: drop it, and skip the rest unless it already ends
      st_drop_s  = 1'b1;
      st_state_s = in_eop ? S_IDLE : S_DISCARD;
    end else begin
      st_we_s = 1'b1;
      if (in_eop) begin
        // Single-word packet
        if (in_err && DROP_EN) begin
          st_drop_s = 1'b1;
        end else begin
          st_ptr_s    = wr_commit_q + ONE_P;
          st_commit_s = wr_commit_q + ONE_P;
          st_pkt_s    = 1'b1;
        end
      end else begin
        st_ptr_s   = wr_commit_q + ONE_P;
        st_state_s = S_PKT;
      end
    end
  end

  // Write FSM: framing repair, commit, error drop and overflow rewind
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    state_d      = state_q;
    we_s         = 1'b0;
    waddr_s      = wr_commit_q[AW-1:0];
    drop_inc_s   = 2'd0;
    pkt_inc_s    = 1'b0;
    take_start_s = 1'b0;
    repair_s     = 1'b0;
    if (in_val) begin
      case (state_q)
        S_IDLE: begin
          // Non-sop words outside a packet are stray and ignored
          take_start_s = in_sop;
        end
        S_PKT: begin
          if (in_sop) begin
            // Previous packet never saw its eop: discard it and restart here
            repair_s     = 1'b1;
            take_start_s = 1'b1;
          end else if (full_s) begin
            // Overflow: throw the partial packet away; an eop word closes it on the spot
            wr_ptr_d   = wr_commit_q;
            drop_inc_s = 2'd1;
            state_d    = in_eop ? S_IDLE : S_DISCARD;
          end else begin
            we_s     = 1'b1;
            waddr_s  = wr_ptr_q[AW-1:0];
            wr_ptr_d = wr_ptr_q + ONE_P;
            if (in_eop) begin
              state_d = S_IDLE;
              if (in_err && DROP_EN) begin
                wr_ptr_d   = wr_commit_q;
                drop_inc_s = 2'd1;
              end else begin
                wr_commit_d = wr_ptr_q + ONE_P;
                pkt_inc_s   = 1'b1;
              end
            end else begin
              state_d = S_PKT;
            end
          end
        end
        S_DISCARD: begin
          if (in_eop) begin
            state_d      = S_IDLE;
            take_start_s = in_sop;
          end else begin
            state_d = S_DISCARD;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end else begin
      state_d = state_q;
    end

    if (take_start_s) begin
      we_s        = st_we_s;
      waddr_s     = wr_commit_q[AW-1:0];
      wr_ptr_d    = st_ptr_s;
      wr_commit_d = st_commit_s;
      state_d     = st_state_s;
      pkt_inc_s   = st_pkt_s;
      drop_inc_s  = {1'b0, st_drop_s} + {1'b0, repair_s};
    end else begin
      drop_inc_s = drop_inc_s;
    end
  end

  // Read side, packet count, saturating drop count and registered status flags
  always_comb begin
    rd_en_s     = out_ren && (rd_ptr_q != wr_commit_q);
    rd_ptr_d    = rd_en_s ? (rd_ptr_q + ONE_P) : rd_ptr_q;
    pkt_dec_s   = rd_en_s && rd_entry_s[1];
    pkt_count_d = pkt_count_q + {{(PW-1){1'b0}}, pkt_inc_s} - {{(PW-1){1'b0}}, pkt_dec_s};
    drop_sum_s  = {1'b0, drop_cnt_q} + {{(CNT_W-1){1'b0}}, drop_inc_s};
    if (drop_sum_s[CNT_W]) begin
      drop_cnt_d = {CNT_W{1'b1}};
    end else begin
      drop_cnt_d = drop_sum_s[CNT_W-1:0];
    end
    free_d_s    = DEPTH_P - (wr_ptr_d - rd_ptr_d);
    in_full_d   = (free_d_s <= THRESH_P);
    out_avail_d = (pkt_count_d != {PW{1'b0}});
  end

  // Packet storage; contents need no reset since pointers gate visibility
  always_ff @(posedge clk_156m25) begin
    if (we_s) begin
      mem_q[waddr_s] <= wdata_s;
    end
  end

  // Pointer, FSM, counter and flag state
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      wr_ptr_q    <= {PW{1'b0}};
      wr_commit_q <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      pkt_count_q <= {PW{1'b0}};
      state_q     <= S_IDLE;
      drop_cnt_q  <= {CNT_W{1'b0}};
      in_full_q   <= 1'b0;
      out_avail_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      wr_commit_q <= wr_commit_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      state_q     <= state_d;
      drop_cnt_q  <= drop_cnt_d;
      in_full_q   <= in_full_d;
      out_avail_q <= out_avail_d;
    end
  end

  // Read data register: one-cycle latency, framing flags pulse only with out_val
  always_ff @(posedge clk_156m25 or negedge reset_156m25_n) begin
    if (!reset_156m25_n) begin
      out_val_q  <= 1'b0;
      out_sop_q  <= 1'b0;
      out_eop_q  <= 1'b0;
      out_err_q  <= 1'b0;
      out_data_q <= {DATA_W{1'b0}};
      out_mod_q  <= {MOD_W{1'b0}};
    end else begin
      out_val_q <= rd_en_s;
      if (rd_en_s) begin
        out_data_q <= rd_entry_s[EW-1 -: DATA_W];
        out_mod_q  <= rd_entry_s[MOD_W+2:3];
        out_sop_q  <= rd_entry_s[2];
        out_eop_q  <= rd_entry_s[1];
        out_err_q  <= rd_entry_s[0];
      end else begin
        out_sop_q <= 1'b0;
        out_eop_q <= 1'b0;
        out_err_q <= 1'b0;
      end
    end
  end

  assign in_full   = in_full_q;
  assign out_avail = out_avail_q;
  assign out_data  = out_data_q;
  assign out_val   = out_val_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_mod   = out_mod_q;
  assign out_err   = out_err_q;
  assign drop_cnt  = drop_cnt_q;

endmodule
